// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port front end for the single-port 64x32 data memory.
//   Port 0 is the core load/store path; port 1 is the debug/DMA path.
//   Round-robin arbitration with an optional bounded burst lock, a word-address
//   range check, and a registered one-cycle response per port.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN/weN/lockN           request, write enable, keep-ownership hint (N=0,1)
//   addrN/wdataN             word address and write data
//   gntN                     combinational grant (request accepted this cycle)
//   rvalidN/rdataN/errN      registered response for the previous cycle's grant
//   mem_read/mem_write       memory strobes (never raised for out-of-range accesses)
//   mem_addr/mem_wdata       memory address and write data
//   mem_rdata                combinational read data from the memory
module dmem_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned ADDR_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic        lock0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic        lock1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    logic       last_gnt;    // port granted most recently (1 after reset so port 0 wins first)
    logic       lock_valid;
    logic       lock_owner;
    logic [3:0] burst_cnt;

    logic oor0, oor1;
    logic any_gnt, sel_port, sel_we, sel_oor, sel_lock;
    logic [31:0] sel_addr, sel_wdata;

    assign oor0 = |addr0[31:ADDR_BITS];
    assign oor1 = |addr1[31:ADDR_BITS];

    // Grant selection; both grants are forced low while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && !req1) begin
                gnt0 = 1'b1;
            end else if (req1 && !req0) begin
                gnt1 = 1'b1;
            end else if (req0 && req1) begin
                // Lock owner keeps the port until its burst count reaches the cap.
                if (lock_valid && (burst_cnt < MAX_B)) begin
                    gnt1 = lock_owner;
                end else begin
                    gnt1 = ~last_gnt;
                end
                gnt0 = ~gnt1;
            end
        end
    end

    assign any_gnt   = gnt0 | gnt1;
    assign sel_port  = gnt1;
    assign sel_we    = gnt1 ? we1    : we0;
    assign sel_oor   = gnt1 ? oor1   : oor0;
    assign sel_lock  = gnt1 ? lock1  : lock0;
    assign sel_addr  = gnt1 ? addr1  : addr0;
    assign sel_wdata = gnt1 ? wdata1 : wdata0;

    // Out-of-range grants still produce a response but never touch the memory.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (any_gnt && !sel_oor) begin
            mem_read  = ~sel_we;
            mem_write = sel_we;
            mem_addr  = sel_addr;
            mem_wdata = sel_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            last_gnt   <= 1'b1;
            lock_valid <= 1'b0;
            lock_owner <= 1'b0;
            burst_cnt  <= '0;
        end else begin
            rvalid0 <= gnt0;
            rvalid1 <= gnt1;
            err0    <= gnt0 & oor0;
            err1    <= gnt1 & oor1;
            rdata0  <= (gnt0 && !we0 && !oor0) ? mem_rdata : '0;
            rdata1  <= (gnt1 && !we1 && !oor1) ? mem_rdata : '0;

            if (any_gnt) begin
                last_gnt <= sel_port;
                if (sel_lock) begin
                    if (lock_valid && (lock_owner == sel_port)) begin
                        if (burst_cnt < MAX_B) begin
                            burst_cnt <= burst_cnt + 4'd1;
                        end
                    end else begin
                        lock_valid <= 1'b1;
                        lock_owner <= sel_port;
                        burst_cnt  <= 4'd1;
                    end
                end else begin
                    lock_valid <= 1'b0;
                    burst_cnt  <= '0;
                end
            end else begin
                // An idle cycle breaks any burst in progress.
                lock_valid <= 1'b0;
                burst_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a
// behavioural 64x32 data memory (combinational read, clocked write) preloaded
// with mem[15]=65 and mem[17]=56.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0] mem [64];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[5:0]];

    dmem_arbiter #(.MAX_BURST(4), .ADDR_BITS(6)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic r, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
        req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
        req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
    endtask

    // Drive at the falling edge, check comb outputs 1ns later, then move
    // to 1ns past the next rising edge for registered checks.
    task automatic to_drive();
        @(negedge clk);
    endtask

    task automatic to_resp();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'(i * 3);
        mem[15] = 32'd65;
        mem[17] = 32'd56;

        rst = 1'b1;
        set0(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        set1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #2;
        chk("reset_gnt0", {31'd0, gnt0}, 32'd0);
        chk("reset_mem_read", {31'd0, mem_read}, 32'd0);
        chk("reset_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("reset_err0", {31'd0, err0}, 32'd0);
        chk("reset_rdata0", rdata0, 32'd0);
        to_resp();

        // Port 0 write then read of addr 5.
        to_drive();
        rst = 1'b0;
        set0(1'b1, 1'b1, 1'b0, 32'd5, 32'h12345678);
        #1;
        chk("wr_gnt0", {31'd0, gnt0}, 32'd1);
        chk("wr_gnt1", {31'd0, gnt1}, 32'd0);
        chk("wr_mem_write", {31'd0, mem_write}, 32'd1);
        chk("wr_mem_read", {31'd0, mem_read}, 32'd0);
        chk("wr_mem_addr", mem_addr, 32'd5);
        chk("wr_mem_wdata", mem_wdata, 32'h12345678);
        to_resp();
        chk("wr_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("wr_rdata0", rdata0, 32'd0);
        chk("wr_rvalid1", {31'd0, rvalid1}, 32'd0);
        to_drive();
        set0(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
        #1;
        chk("rd_gnt0", {31'd0, gnt0}, 32'd1);
        chk("rd_mem_read", {31'd0, mem_read}, 32'd1);
        to_resp();
        chk("rd_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("rd_rdata0", rdata0, 32'h12345678);
        chk("rd_err0", {31'd0, err0}, 32'd0);
        to_drive();
        set0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        to_resp();
        chk("idle_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("idle_rdata0", rdata0, 32'd0);

        // Port 1 alone reads addr 17 (last_gnt becomes 1).
        to_drive();
        set1(1'b1, 1'b0, 1'b0, 32'd17, 32'd0);
        #1;
        chk("p1_gnt1", {31'd0, gnt1}, 32'd1);
        to_resp();
        chk("p1_rvalid1", {31'd0, rvalid1}, 32'd1);
        chk("p1_rdata1", rdata1, 32'd56);

        // Contention without lock: 0,1,0,1.
        to_drive();
        set0(1'b1, 1'b0, 1'b0, 32'd15, 32'd0);
        set1(1'b1, 1'b0, 1'b0, 32'd17, 32'd0);
        #1;
        chk("rr1_gnt0", {31'd0, gnt0}, 32'd1);
        chk("rr1_gnt1", {31'd0, gnt1}, 32'd0);
        to_resp();
        chk("rr1_rdata0", rdata0, 32'd65);
        chk("rr1_rvalid1", {31'd0, rvalid1}, 32'd0);
        to_drive();
        #1;
        chk("rr2_gnt1", {31'd0, gnt1}, 32'd1);
        chk("rr2_gnt0", {31'd0, gnt0}, 32'd0);
        to_resp();
        chk("rr2_rdata1", rdata1, 32'd56);
        chk("rr2_rvalid0", {31'd0, rvalid0}, 32'd0);
        to_drive();
        #1;
        chk("rr3_gnt0", {31'd0, gnt0}, 32'd1);
        to_resp();
        to_drive();
        #1;
        chk("rr4_gnt1", {31'd0, gnt1}, 32'd1);
        to_resp();
        // Port 0 alone once more so last_gnt is 0.
        to_drive();
        set1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("solo0_gnt0", {31'd0, gnt0}, 32'd1);
        to_resp();

        // Locked burst from port 1 against a waiting port 0: 1,1,1,1 then 0.
        to_drive();
        set1(1'b1, 1'b0, 1'b1, 32'd17, 32'd0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("lock%0d_gnt1", k), {31'd0, gnt1}, 32'd1);
            chk($sformatf("lock%0d_gnt0", k), {31'd0, gnt0}, 32'd0);
            to_resp();
            to_drive();
        end
        #1;
        chk("cap_gnt0", {31'd0, gnt0}, 32'd1);
        chk("cap_gnt1", {31'd0, gnt1}, 32'd0);
        to_resp();
        chk("cap_rdata0", rdata0, 32'd65);
        to_drive();
        set0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("after_cap_gnt1", {31'd0, gnt1}, 32'd1);
        to_resp();
        chk("after_cap_rdata1", rdata1, 32'd56);

        // Out-of-range read on port 0.
        to_drive();
        set1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set0(1'b1, 1'b0, 1'b0, 32'h40, 32'd0);
        #1;
        chk("oor_gnt0", {31'd0, gnt0}, 32'd1);
        chk("oor_mem_read", {31'd0, mem_read}, 32'd0);
        chk("oor_mem_write", {31'd0, mem_write}, 32'd0);
        to_resp();
        chk("oor_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("oor_err0", {31'd0, err0}, 32'd1);
        chk("oor_rdata0", rdata0, 32'd0);

        // Reset in the response cycle discards the response at once.
        to_drive();
        set0(1'b1, 1'b0, 1'b0, 32'd17, 32'd0);
        to_resp();
        chk("pre_rst_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("pre_rst_err0", {31'd0, err0}, 32'd0);
        set0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        to_drive();
        rst = 1'b0;
        set0(1'b1, 1'b0, 1'b0, 32'd17, 32'd0);
        set1(1'b1, 1'b0, 1'b0, 32'd15, 32'd0);
        #1;
        chk("post_rst_gnt0", {31'd0, gnt0}, 32'd1);
        chk("post_rst_gnt1", {31'd0, gnt1}, 32'd0);
        to_resp();
        chk("preload17_rdata0", rdata0, 32'd56);
        to_drive();
        set0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("post_rst2_gnt1", {31'd0, gnt1}, 32'd1);
        to_resp();
        chk("preload15_rdata1", rdata1, 32'd65);
        chk("preload15_rvalid0", {31'd0, rvalid0}, 32'd0);
        to_drive();
        set1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        to_resp();
        chk("final_rvalid1", {31'd0, rvalid1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
